// File: rtl/pwm_cfg_pkg.sv
// Shared configuration for the PWM block: register address map, ramp FSM states, duty width.
package pwm_cfg_pkg;

  localparam int DUTY_W = 8;

  // Register address map, also used by the SPI peripheral's decoder
  localparam logic [6:0] REG_ADDR_TARGET = 7'h05;
  localparam logic [6:0] REG_ADDR_STEP   = 7'h06;
  localparam logic [6:0] REG_ADDR_PERIOD = 7'h07;
  localparam logic [6:0] REG_ADDR_MODE   = 7'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Step timer: prescaler (0..PRESCALE-1) feeding a period counter (0..period_q).
// step_evt pulses once every (period_q+1)*PRESCALE enabled cycles.
module ramp_tick_gen
  import pwm_cfg_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [DUTY_W-1:0] period_q,
  output logic              step_evt
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [DUTY_W-1:0] per_q, per_d;
  logic              tick;

  assign tick = enable && (presc_q == PS_W'(PRESCALE - 1));
  // >= lets the step fire at once if PERIOD shrank below the running count
  assign step_evt = tick && (per_q >= period_q);

  // Next count: clear wins, counters hold while disabled, wrap at terminal counts
  always_comb begin
    presc_d = presc_q;
    per_d   = per_q;
    if (clear) begin
      presc_d = '0;
      per_d   = '0;
    end else if (enable) begin
      if (tick) begin
        presc_d = '0;
        per_d   = (per_q >= period_q) ? '0 : per_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      per_q   <= '0;
    end else begin
      presc_q <= presc_d;
      per_q   <= per_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramps duty_out toward an SPI-written TARGET in STEP-sized increments every
// (PERIOD+1)*PRESCALE clocks. STEP=0 jumps straight to TARGET.
// Optional macro PWM_RAMP_LOOP_EN adds the MODE register: loop=1 swaps the
// start and target on every completion to produce a triangle "breathing" ramp.
module pwm_ramp_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int         PRESCALE    = 100,
  parameter logic [6:0] ADDR_TARGET = REG_ADDR_TARGET,
  parameter logic [6:0] ADDR_STEP   = REG_ADDR_STEP,
  parameter logic [6:0] ADDR_PERIOD = REG_ADDR_PERIOD,
  parameter logic [6:0] ADDR_MODE   = REG_ADDR_MODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic [DUTY_W-1:0] period_q, period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              done_q, done_d;
  ramp_state_e       state_q, state_d;
`ifdef PWM_RAMP_LOOP_EN
  logic              mode_q, mode_d;
  logic [DUTY_W-1:0] start_q, start_d;
`endif

  logic              wr_target;
  logic              ramp_active;
  logic              step_evt;
  logic [DUTY_W:0]   sum9, diff9;
  logic [DUTY_W-1:0] up_val, dn_val;

  assign wr_target   = wr_valid && (wr_addr == ADDR_TARGET);
  assign ramp_active = (state_q != ST_IDLE);

  ramp_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!ramp_active || wr_target),
    .enable   (ramp_active),
    .period_q (period_q),
    .step_evt (step_evt)
  );

  // Saturating step arithmetic; the 9th bit catches carry/borrow past 255/0
  always_comb begin
    sum9   = {1'b0, duty_q} + {1'b0, step_q};
    diff9  = {1'b0, duty_q} - {1'b0, step_q};
    up_val = (sum9 >= {1'b0, target_q}) ? target_q : sum9[DUTY_W-1:0];
    dn_val = (diff9[DUTY_W] || (diff9[DUTY_W-1:0] <= target_q)) ? target_q : diff9[DUTY_W-1:0];
  end

  // Register writes, FSM next state and duty update; a TARGET write restarts the ramp
  always_comb begin
    target_d = target_q;
    step_d   = step_q;
    period_d = period_q;
    duty_d   = duty_q;
    state_d  = state_q;
    done_d   = 1'b0;
`ifdef PWM_RAMP_LOOP_EN
    mode_d   = mode_q;
    start_d  = start_q;
`endif

    if (wr_valid) begin
      if (wr_addr == ADDR_TARGET) begin
        target_d = wr_data;
`ifdef PWM_RAMP_LOOP_EN
        start_d  = duty_q;
`endif
      end else if (wr_addr == ADDR_STEP) begin
        step_d = wr_data;
      end else if (wr_addr == ADDR_PERIOD) begin
        period_d = wr_data;
      end else if (wr_addr == ADDR_MODE) begin
`ifdef PWM_RAMP_LOOP_EN
        mode_d = wr_data[0];
`endif
        // without the loop feature MODE has no storage; the write is dropped
      end
    end

    if (wr_target) begin
      // restart: drop any coincident step, re-pick direction next cycle
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (target_q > duty_q)      state_d = ST_UP;
          else if (target_q < duty_q) state_d = ST_DOWN;
        end
        ST_UP, ST_DOWN: begin
          if ((step_q == '0) || step_evt) begin
            if (step_q == '0)          duty_d = target_q;
            else if (state_q == ST_UP) duty_d = up_val;
            else                       duty_d = dn_val;
            if (duty_d == target_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
`ifdef PWM_RAMP_LOOP_EN
              if (mode_q) begin
                target_d = start_q;
                start_d  = target_q;
              end
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      step_q   <= 8'd1;
      period_q <= '0;
      duty_q   <= '0;
      done_q   <= 1'b0;
      state_q  <= ST_IDLE;
`ifdef PWM_RAMP_LOOP_EN
      mode_q   <= 1'b0;
      start_q  <= '0;
`endif
    end else begin
      target_q <= target_d;
      step_q   <= step_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      done_q   <= done_d;
      state_q  <= state_d;
`ifdef PWM_RAMP_LOOP_EN
      mode_q   <= mode_d;
      start_q  <= start_d;
`endif
    end
  end

  assign duty_out = duty_q;
  assign busy     = (duty_q != target_q);
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with PRESCALE=4.
// Loop-mode steps are included when PWM_RAMP_LOOP_EN is defined.
module tb_pwm_ramp_sequencer;

  localparam logic [6:0] A_TARGET = 7'h05;
  localparam logic [6:0] A_STEP   = 7'h06;
  localparam logic [6:0] A_PERIOD = 7'h07;
  localparam logic [6:0] A_MODE   = 7'h08;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  pwm_ramp_sequencer #(.PRESCALE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .duty_out (duty_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  // advance to the next falling edge and sample the pulse outputs
  task automatic tick();
    @(negedge clk);
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // wait for duty_out to change, then check value, cycles taken, done and busy
  task automatic wait_change(input string tag, input int exp_duty, input int exp_n,
                             input bit exp_done, input bit exp_busy);
    logic [7:0] prev;
    int n;
    prev = duty_out;
    n = 0;
    do begin
      tick();
      n++;
    end while (duty_out == prev && n < 300);
    chk({tag, "_duty"}, duty_out, exp_duty);
    chk({tag, "_cyc"},  n,        exp_n);
    chk({tag, "_done"}, done,     exp_done);
    chk({tag, "_busy"}, busy,     exp_busy);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_duty", duty_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // STEP=10, PERIOD=0: 0 -> 35 in steps of 10, one step per 4 clocks
    wr(A_STEP, 8'd10);
    wr(A_PERIOD, 8'd0);
    done_cnt = 0;
    wr(A_TARGET, 8'd35);
    chk("up_busy_start", busy, 1);
    wait_change("up10", 10, 5, 0, 1);
    wait_change("up20", 20, 4, 0, 1);
    wait_change("up30", 30, 4, 0, 1);
    wait_change("up35", 35, 4, 1, 0);
    tick();
    chk("up_done_1cyc", done, 0);
    repeat (6) tick();
    chk("up_done_cnt", done_cnt, 1);
    chk("up_hold", duty_out, 35);

    // STEP=0 jump to 255, then jump down to 200
    wr(A_STEP, 8'd0);
    done_cnt = 0;
    wr(A_TARGET, 8'd255);
    wait_change("jump255", 255, 2, 1, 0);
    repeat (4) tick();
    chk("jump_done_cnt", done_cnt, 1);
    wr(A_TARGET, 8'd200);
    wait_change("jump200", 200, 2, 1, 0);

    // STEP=60 down to 50, clamped on the last step
    wr(A_STEP, 8'd60);
    done_cnt = 0;
    wr(A_TARGET, 8'd50);
    wait_change("dn140", 140, 5, 0, 1);
    wait_change("dn80", 80, 4, 0, 1);
    wait_change("dn50", 50, 4, 1, 0);
    repeat (4) tick();
    chk("dn_done_cnt", done_cnt, 1);

    // 50-60 must saturate at 0, not wrap
    wr(A_TARGET, 8'd0);
    wait_change("dn_floor", 0, 5, 1, 0);

    // PERIOD=1 doubles the step interval
    wr(A_PERIOD, 8'd1);
    wr(A_STEP, 8'd10);
    wr(A_TARGET, 8'd20);
    wait_change("per10", 10, 9, 0, 1);
    wait_change("per20", 20, 8, 1, 0);

    // mid-ramp reversal; the TARGET write lands on a step edge and must win
    wr(A_PERIOD, 8'd0);
    done_cnt = 0;
    wr(A_TARGET, 8'd100);
    wait_change("rev30", 30, 5, 0, 1);
    tick(); tick(); tick();
    wr(A_TARGET, 8'd0);
    chk("rev_step_dropped", duty_out, 30);
    wait_change("rev20", 20, 5, 0, 1);
    wait_change("rev10", 10, 4, 0, 1);
    wait_change("rev0", 0, 4, 1, 0);
    repeat (4) tick();
    chk("rev_done_cnt", done_cnt, 1);

    // TARGET equal to current duty: no ramp, no done
    done_cnt = 0;
    busy_cnt = 0;
    wr(A_TARGET, 8'd0);
    repeat (8) tick();
    chk("eq_done_cnt", done_cnt, 0);
    chk("eq_busy_cnt", busy_cnt, 0);
    chk("eq_duty", duty_out, 0);

    // reset mid-ramp, then confirm STEP/PERIOD returned to 1/0
    wr(A_PERIOD, 8'd2);
    wr(A_STEP, 8'd10);
    wr(A_TARGET, 8'd100);
    wait_change("pre_rst10", 10, 13, 0, 1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_duty", duty_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    tick();
    wr(A_TARGET, 8'd3);
    wait_change("rst_step1", 1, 5, 0, 1);
    wait_change("rst_step2", 2, 4, 0, 1);
    wait_change("rst_step3", 3, 4, 1, 0);

`ifdef PWM_RAMP_LOOP_EN
    // loop mode: 0 -> 20 -> 0 -> 10, then loop off finishes the leg at 20
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr(A_MODE, 8'd1);
    wr(A_STEP, 8'd10);
    done_cnt = 0;
    wr(A_TARGET, 8'd20);
    wait_change("loop10a", 10, 5, 0, 1);
    wait_change("loop20", 20, 4, 1, 1);
    wait_change("loop10b", 10, 5, 0, 1);
    wait_change("loop0", 0, 4, 1, 1);
    wait_change("loop10c", 10, 5, 0, 1);
    wr(A_MODE, 8'd0);
    wait_change("loop_end", 20, 3, 1, 0);
    repeat (10) tick();
    chk("loop_idle_duty", duty_out, 20);
    chk("loop_done_cnt", done_cnt, 3);
`else
    // MODE writes are dropped; a following ramp behaves normally
    wr(A_MODE, 8'd1);
    wr(A_TARGET, 8'd5);
    wait_change("nomode4", 4, 5, 0, 1);
    wait_change("nomode5", 5, 4, 1, 0);
    repeat (10) tick();
    chk("nomode_hold", duty_out, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
